// File: rtl/sub_div_ctrl.sv
// 32-bit unsigned restoring divider. It produces one quotient bit per clock by sharing a single
// sub32 subtractor, and uses a start/busy/done handshake.
module sub_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic [1:0]  state_dbg
);

  // Handshake: start is accepted only in IDLE. busy is high from the edge after acceptance
  // through the DONE cycle. done pulses for that single DONE cycle, and the results are valid
  // while done is high and after it.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_n;
  logic [31:0] r, q, d;
  logic [4:0]  cnt;
  logic [31:0] s_low, diff, r_step, q_step;
  logic        take;

  // The low 32 bits of the shifted partial remainder {R, Q[31]} feed the subtractor. The shifted-out
  // bit R[31] forces a take, because the wrap-around difference is then still correct.
  assign s_low  = {r[30:0], q[31]};
  assign take   = r[31] | (s_low >= d);
  assign r_step = take ? diff : s_low;
  assign q_step = {q[30:0], take};

  sub32 u_sub (
    .op1  (s_low),
    .op2  (d),
    .diff (diff)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (divisor == 32'd0) ? DONE : RUN;
      RUN:     if (cnt == 5'd31) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == 32'd0) begin
              quotient    <= 32'hFFFF_FFFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              r           <= '0;
              q           <= dividend;
              d           <= divisor;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          r   <= r_step;
          q   <= q_step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            quotient  <= q_step;
            remainder <= r_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// Shared 32-bit subtractor datapath.
module sub32 (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] diff
);
  assign diff = op1 - op2;
endmodule

// File: doc/sub_div_ctrl.md
# sub_div_ctrl

Sequential controller that drives one shared `Sub32` subtractor to perform 32-bit unsigned restoring division, one quotient bit per clock. Takes a start/operands request, iterates 32 times through the subtractor, and returns the quotient and remainder with a one-cycle `done` pulse. This is the first multi-cycle arithmetic unit built on the `Sub32` datapath; later ALU work reuses its start/busy/done handshake.

## Interface

- Parameters: none (width fixed at 32; iteration count fixed at 32).
- One clock; reset is synchronous and active-high.
- `clk` in 1: sole clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request strobe, sampled only in IDLE.
- `dividend` in 32: unsigned dividend, sampled with `start`.
- `divisor` in 32: unsigned divisor, sampled with `start`.
- `busy` out 1: high from the edge after an accepted `start` until return to IDLE, including the DONE cycle.
- `done` out 1: one-cycle pulse, high in the DONE state only.
- `quotient` out 32: result quotient, registered.
- `remainder` out 32: result remainder, registered.
- `div_by_zero` out 1: registered flag, set for a request with `divisor == 0`.

## Operation

- Internal `Sub32` instance:
  - `op1` = low 32 bits of the shifted partial remainder.
  - `op2` = latched divisor.
  - `diff` is the trial result.
- Internal registers:
  - R: partial remainder, 32 bits.
  - Q: dividend/quotient shift register, 32 bits.
  - D: divisor, 32 bits.
  - cnt: 5-bit counter.
  - state.
- States are IDLE, RUN and DONE.
- **IDLE**
  - Accepting `start` with `divisor != 0`: load R=0, Q=`dividend`, D=`divisor`, cnt=0, clear `div_by_zero`, go to RUN.
  - Accepting `start` with `divisor == 0`: set `quotient`=32'hFFFFFFFF, `remainder`=`dividend`, `div_by_zero`=1, go directly to DONE.
- **RUN, each cycle**
  - Shifted value S = {R, Q[31]} (33 bits).
  - take = R[31] | (S[31:0] >= D), using an unsigned compare.
    - When R[31]=1, S ≥ 2^32 > D, and the 32-bit `diff` is still the correct modulo result.
  - R ← take ? `diff` : S[31:0].
  - Q ← {Q[30:0], take}.
  - cnt ← cnt+1.
  - When cnt==31, the iteration in that cycle is the last one: copy the updated Q to `quotient` and the updated R to `remainder`, then go to DONE.
- **DONE**
  - `done`=1 and `busy`=1 for exactly one cycle.
  - Then go to IDLE unconditionally.
- Outputs `quotient`, `remainder` and `div_by_zero` hold their values after DONE until the next accepted request overwrites them.
  - For a non-zero divisor, they change only at the last RUN edge.
- `start` while in RUN or DONE is ignored. No queueing; the operands on those cycles are dropped.
- `start` held high continuously re-triggers a new operation on every IDLE cycle.

## Timing

- Edge T0: `start` sampled high in IDLE.
- Non-zero divisor:
  - RUN covers edges T1..T32.
  - Results are valid and `done`=1 after T32.
  - IDLE after T33.
  - Total latency from the accepting edge to `done` is 32 cycles.
  - Earliest next acceptance is T34 (start sampled high in IDLE).
- Zero divisor:
  - `done`=1 after T0, so latency is 1 cycle.
  - IDLE after T1.
- `busy` is low in IDLE and high in RUN and DONE.
- Reset value of every output is 0: `busy`, `done`, `quotient`, `remainder`, `div_by_zero`. Reset state is IDLE.
- Internal registers R, Q, D and cnt are also cleared by reset.
- Reset asserted mid-operation, including in DONE:
  - After that edge, state is IDLE and all outputs are 0.
  - The in-flight result is discarded and no `done` is produced.
- `rst` and `start` asserted in the same cycle: reset wins and the request is dropped.

## Test plan

- 100 / 7 with `start` at T0 → `busy`=1 after T0; `done`=1 only after T32; `quotient`=14, `remainder`=2; IDLE after T33.
- 4 / 7, then 32'h80000007 / 4 → `quotient`=0, `remainder`=4; then `quotient`=32'h20000001, `remainder`=3.
- 32'hFFFFFFFF / 1, then 32'hFFFFFFFF / 32'h80000000 (exercises the R[31] take path) → `quotient`=32'hFFFFFFFF, `remainder`=0; then `quotient`=1, `remainder`=32'h7FFFFFFF.
- 5 / 0 → `done`=1 after T0; `quotient`=32'hFFFFFFFF, `remainder`=5, `div_by_zero`=1. A following 9 / 3 clears the flag and gives `quotient`=3, `remainder`=0.
- Start 100 / 7, then pulse `start` with 1 / 1 at T5, then assert `rst` at T10 → the T5 request is ignored; after T10 `busy`, `done` and all results are 0; no `done` pulse follows.
- Start 100 / 7, then hold `start` high with 50 / 6 throughout → the first result is 14 / 2. The second request is accepted at T34 and completes with 8 / 2 at T66.
